// File: rtl/fc_pkg.sv
// Shared FC-datapath types and default widths for the neuron accumulator.
// ACC_MAX/ACC_MIN are the saturation limits at the default accumulator width.
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_DATA_LENGTH = 27;
    localparam int DEF_ACC_LENGTH  = 32;
    localparam int DEF_COUNT_WIDTH = 10;

    localparam logic signed [DEF_ACC_LENGTH-1:0] ACC_MAX = {1'b0, {(DEF_ACC_LENGTH-1){1'b1}}};
    localparam logic signed [DEF_ACC_LENGTH-1:0] ACC_MIN = {1'b1, {(DEF_ACC_LENGTH-1){1'b0}}};

endpackage

// File: rtl/neuron_accumulator_if.sv
// Beat-in / sum-out bundle between the lane mux, the accumulator and the activation stage.
// master = the surrounding datapath, slave = neuron_accumulator.
interface neuron_accumulator_if
    import fc_pkg::*;
#(
    parameter int DATA_LENGTH = DEF_DATA_LENGTH,
    parameter int ACC_LENGTH  = DEF_ACC_LENGTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) ();

    logic                          start;
    logic [COUNT_WIDTH-1:0]        beat_count;
    logic signed [DATA_LENGTH-1:0] in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [1:0]                    mux_sel;
    logic signed [ACC_LENGTH-1:0]  out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic                          busy;

    modport master (
        output start, beat_count, in_data, in_valid, out_ready,
        input  in_ready, mux_sel, out_data, out_valid, busy
    );

    modport slave (
        input  start, beat_count, in_data, in_valid, out_ready,
        output in_ready, mux_sel, out_data, out_valid, busy
    );

endinterface

// File: rtl/sat_adder.sv
// Sign-extending accumulator adder, purely combinational (zero latency, no handshake).
// With ACC_SATURATE_EN defined, signed overflow clamps to the most-positive/most-negative value.
module sat_adder
    import fc_pkg::*;
#(
    parameter int DATA_LENGTH = DEF_DATA_LENGTH,
    parameter int ACC_LENGTH  = DEF_ACC_LENGTH
) (
    input  logic signed [ACC_LENGTH-1:0]  i_acc,
    input  logic signed [DATA_LENGTH-1:0] i_data,
    output logic signed [ACC_LENGTH-1:0]  o_sum
);

    logic signed [ACC_LENGTH-1:0] w_ext;
    logic signed [ACC_LENGTH-1:0] w_raw;

    assign w_ext = ACC_LENGTH'(i_data);
    assign w_raw = i_acc + w_ext;

`ifdef ACC_SATURATE_EN
    localparam logic signed [ACC_LENGTH-1:0] SAT_MAX = {1'b0, {(ACC_LENGTH-1){1'b1}}};
    localparam logic signed [ACC_LENGTH-1:0] SAT_MIN = {1'b1, {(ACC_LENGTH-1){1'b0}}};

    logic w_ovf;

    // Overflow only possible when both operands share a sign and the result flips it.
    assign w_ovf = (i_acc[ACC_LENGTH-1] == w_ext[ACC_LENGTH-1]) &&
                   (w_raw[ACC_LENGTH-1] != i_acc[ACC_LENGTH-1]);
    assign o_sum = w_ovf ? (i_acc[ACC_LENGTH-1] ? SAT_MIN : SAT_MAX) : w_raw;
`else
    assign o_sum = w_raw;
`endif

endmodule

// File: rtl/neuron_accumulator.sv
// Accumulates beat_count signed products into one pre-activation sum; result one cycle after last beat.
// Beats stall freely on in_valid; the result is held in HOLD until out_ready (saturation via ACC_SATURATE_EN).
module neuron_accumulator
    import fc_pkg::*;
#(
    parameter int DATA_LENGTH = DEF_DATA_LENGTH,
    parameter int ACC_LENGTH  = DEF_ACC_LENGTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    neuron_accumulator_if.slave bus
);

    state_t                       r_state;
    state_t                       w_next_state;
    logic signed [ACC_LENGTH-1:0] r_acc;
    logic [COUNT_WIDTH-1:0]       r_remaining;
    logic [1:0]                   r_mux_sel;
    logic signed [ACC_LENGTH-1:0] r_out_data;
    logic                         r_out_valid;

    logic                         w_beat;
    logic                         w_last_beat;
    logic signed [ACC_LENGTH-1:0] w_sum;

    sat_adder #(
        .DATA_LENGTH (DATA_LENGTH),
        .ACC_LENGTH  (ACC_LENGTH)
    ) u_sat_adder (
        .i_acc  (r_acc),
        .i_data (bus.in_data),
        .o_sum  (w_sum)
    );

    assign w_beat      = bus.in_valid && (r_state == ACCUM);
    assign w_last_beat = w_beat && (r_remaining == COUNT_WIDTH'(1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next_state = (bus.beat_count != '0) ? ACCUM : HOLD;
            ACCUM:   if (w_last_beat) w_next_state = HOLD;
            HOLD:    if (bus.out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_remaining <= '0;
            r_mux_sel   <= 2'd0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.beat_count != '0) begin
                            r_acc       <= '0;
                            r_remaining <= bus.beat_count;
                            r_mux_sel   <= 2'd0;
                        end else begin
                            r_out_data  <= '0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    // mux_sel only advances on an accepted beat so a stalled product stays selected.
                    if (w_beat) begin
                        r_acc       <= w_sum;
                        r_remaining <= r_remaining - COUNT_WIDTH'(1);
                        r_mux_sel   <= r_mux_sel + 2'd1;
                        if (w_last_beat) begin
                            r_out_data  <= w_sum;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) r_out_valid <= 1'b0;
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ACCUM);
    assign bus.busy      = (r_state != IDLE);
    assign bus.mux_sel   = r_mux_sel;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;

endmodule
